// File: rtl/audio_mix_sequencer_if.sv
// rtl/audio_mix_sequencer_if.sv - compressor ROM read bus between mixer sequencer and its lookup table
interface audio_mix_sequencer_if;
    logic        rom_en;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/audio_mix_sequencer.sv
// rtl/audio_mix_sequencer.sv - sequential stereo mixer of 2xAY, beeper and specdrum with ROM compressor
module audio_mix_sequencer (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          sample_tick,
    input  logic [7:0]                    mixer,
    input  logic [7:0]                    ay1_cha,
    input  logic [7:0]                    ay1_chb,
    input  logic [7:0]                    ay1_chc,
    input  logic [7:0]                    ay2_cha,
    input  logic [7:0]                    ay2_chb,
    input  logic [7:0]                    ay2_chc,
    input  logic [7:0]                    beeper,
    input  logic [7:0]                    specdrum_left,
    input  logic [7:0]                    specdrum_right,
    audio_mix_sequencer_if.master         rom,
    output logic [7:0]                    left,
    output logic [7:0]                    right,
    output logic                          valid,
    output logic                          busy,
    output logic                          overrun
);

    typedef enum logic [2:0] {IDLE, ACC, LUT_L, LUT_R, CAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [10:0] acc_l_q, acc_l_d;
    logic [10:0] acc_r_q, acc_r_d;
    logic [7:0]  mix_q, mix_d;
    // Snapshot ordered by accumulation index; slot 7 holds specdrum_left.
    logic [7:0]  src_q [8];
    logic [7:0]  src_d [8];
    logic [7:0]  sdr_q, sdr_d;
    logic [7:0]  lat_l_q, lat_l_d;
    logic [7:0]  left_q, left_d;
    logic [7:0]  right_q, right_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;

    logic        pan_l, pan_r;
    logic [10:0] add_l, add_r;
    logic        rom_en_c;
    logic [10:0] rom_addr_c;

    always_comb begin
        pan_l = 1'b0;
        pan_r = 1'b0;
        case (idx_q[2:1])
            2'd0:    {pan_l, pan_r} = mix_q[7:6];
            2'd1:    {pan_l, pan_r} = mix_q[5:4];
            2'd2:    {pan_l, pan_r} = mix_q[3:2];
            default: {pan_l, pan_r} = mix_q[1:0];
        endcase
    end

    always_comb begin
        add_l = {4'b0, src_q[idx_q][7:1]};
        add_r = {4'b0, src_q[idx_q][7:1]};
        if (idx_q == 3'd6) begin
            add_l = {3'b0, src_q[6]};
            add_r = {3'b0, src_q[6]};
        end else if (idx_q == 3'd7) begin
            add_l = {{3{src_q[7][7]}}, src_q[7]};
            add_r = {{3{sdr_q[7]}}, sdr_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        mix_d      = mix_q;
        src_d      = src_q;
        sdr_d      = sdr_q;
        lat_l_d    = lat_l_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = 1'b0;
        ovr_d      = ovr_q | (sample_tick && (state_q != IDLE));
        rom_en_c   = 1'b0;
        rom_addr_c = 11'd0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    mix_d    = mixer;
                    src_d[0] = ay1_cha;
                    src_d[1] = ay2_cha;
                    src_d[2] = ay1_chb;
                    src_d[3] = ay2_chb;
                    src_d[4] = ay1_chc;
                    src_d[5] = ay2_chc;
                    src_d[6] = beeper;
                    src_d[7] = specdrum_left;
                    sdr_d    = specdrum_right;
                    acc_l_d  = 11'd0;
                    acc_r_d  = 11'd0;
                    idx_d    = 3'd0;
                    state_d  = ACC;
                end
            end
            ACC: begin
                // Wraps modulo 2048 by width; overflow is intentional.
                if (pan_l) acc_l_d = acc_l_q + add_l;
                if (pan_r) acc_r_d = acc_r_q + add_r;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = LUT_L;
            end
            LUT_L: begin
                rom_en_c   = 1'b1;
                rom_addr_c = acc_l_q;
                state_d    = LUT_R;
            end
            LUT_R: begin
                rom_en_c   = 1'b1;
                rom_addr_c = acc_r_q;
                lat_l_d    = rom.rom_data;
                state_d    = CAP;
            end
            CAP: begin
                left_d  = lat_l_q;
                right_d = rom.rom_data;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            acc_l_q <= 11'd0;
            acc_r_q <= 11'd0;
            mix_q   <= 8'd0;
            for (int i = 0; i < 8; i++) src_q[i] <= 8'd0;
            sdr_q   <= 8'd0;
            lat_l_q <= 8'd0;
            left_q  <= 8'd0;
            right_q <= 8'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            mix_q   <= mix_d;
            src_q   <= src_d;
            sdr_q   <= sdr_d;
            lat_l_q <= lat_l_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rom.rom_en   = rom_en_c;
    assign rom.rom_addr = rom_addr_c;
    assign left         = left_q;
    assign right        = right_q;
    assign valid        = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// tb/tb_audio_mix_sequencer.sv - scoreboard bench for audio_mix_sequencer with 1-cycle ROM model
module tb_audio_mix_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] mixer = 8'd0;
    logic [7:0] ay1_cha = 8'd0, ay1_chb = 8'd0, ay1_chc = 8'd0;
    logic [7:0] ay2_cha = 8'd0, ay2_chb = 8'd0, ay2_chc = 8'd0;
    logic [7:0] beeper = 8'd0, specdrum_left = 8'd0, specdrum_right = 8'd0;
    logic [7:0] left, right;
    logic       valid, busy, overrun;

    audio_mix_sequencer_if rom_bus ();

    audio_mix_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .sample_tick    (sample_tick),
        .mixer          (mixer),
        .ay1_cha        (ay1_cha),
        .ay1_chb        (ay1_chb),
        .ay1_chc        (ay1_chc),
        .ay2_cha        (ay2_cha),
        .ay2_chb        (ay2_chb),
        .ay2_chc        (ay2_chc),
        .beeper         (beeper),
        .specdrum_left  (specdrum_left),
        .specdrum_right (specdrum_right),
        .rom            (rom_bus),
        .left           (left),
        .right          (right),
        .valid          (valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 Clk = ~Clk;

    // ROM: data = addr[10:3], one cycle after the enabled read.
    always @(posedge Clk) begin
        if (Reset) rom_bus.rom_data <= 8'd0;
        else if (rom_bus.rom_en) rom_bus.rom_data <= rom_bus.rom_addr[10:3];
    end

    logic [15:0] exp_q [$];
    logic [10:0] addr_q [$];
    logic [15:0] mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_expected();
        logic [10:0] l, r;
        logic [7:0]  ay [6];
        l = 11'd0;
        r = 11'd0;
        ay[0] = ay1_cha; ay[1] = ay2_cha; ay[2] = ay1_chb;
        ay[3] = ay2_chb; ay[4] = ay1_chc; ay[5] = ay2_chc;
        for (int k = 0; k < 6; k++) begin
            if (mixer[7 - 2 * (k / 2)]) l = l + 11'(ay[k] / 2);
            if (mixer[6 - 2 * (k / 2)]) r = r + 11'(ay[k] / 2);
        end
        if (mixer[1]) l = l + 11'(beeper);
        if (mixer[0]) r = r + 11'(beeper);
        if (mixer[1]) l = l + {{3{specdrum_left[7]}}, specdrum_left};
        if (mixer[0]) r = r + {{3{specdrum_right[7]}}, specdrum_right};
        exp_q.push_back({l[10:3], r[10:3]});
        addr_q.push_back(l);
        addr_q.push_back(r);
    endfunction

    always @(negedge Clk) begin
        if (!Reset) begin
            if (valid) begin
                n_valid++;
                check("valid_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("left", left, mon_e[15:8]);
                    check("right", right, mon_e[7:0]);
                end
            end
            if (rom_bus.rom_en) begin
                check("rom_read_expected", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) check("rom_addr", rom_bus.rom_addr, addr_q.pop_front());
            end else begin
                check("rom_addr_when_off", rom_bus.rom_addr, 0);
            end
        end
    end

    task automatic set_src(input logic [7:0] m, a1a, a2a, a1b, a2b, a1c, a2c, bp, sl, sr);
        mixer = m;
        ay1_cha = a1a; ay2_cha = a2a; ay1_chb = a1b;
        ay2_chb = a2b; ay1_chc = a1c; ay2_chc = a2c;
        beeper = bp; specdrum_left = sl; specdrum_right = sr;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        push_expected();
        @(posedge Clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
        end while (!valid && cyc < 40);
    endtask

    task automatic run(input string tag);
        int c;
        @(negedge Clk);
        tick();
        wait_valid(c);
        check({tag, "_latency"}, c, 11);
        @(negedge Clk);
        check({tag, "_valid_width"}, valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int saved;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_valid", valid, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_rom_en", rom_bus.rom_en, 0);
        check("rst_rom_addr", rom_bus.rom_addr, 0);
        Reset = 1'b0;

        set_src(8'hFF, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
        run("single_ay");
        check("single_ay_no_overrun", overrun, 0);
        set_src(8'h02, 0, 0, 0, 0, 0, 0, 0, 8'hF0, 0);
        run("specdrum_neg");
        set_src(8'hAA, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 0, 0);
        run("all_left");
        set_src(8'h00, 8'h77, 8'h12, 8'hFF, 8'h9A, 8'h40, 8'h33, 8'hC8, 8'h80, 8'h7F);
        run("mixer_zero");
        set_src(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80);
        run("full_scale");
        for (int i = 0; i < 6; i++) begin
            set_src(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
            run("random");
        end

        // Second tick sampled at E5 must be dropped and flag overrun.
        set_src(8'h5A, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'h11, 8'hE0, 8'h22);
        @(negedge Clk);
        tick();
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        sample_tick = 1'b1;
        @(posedge Clk);
        #1 sample_tick = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("overrun_set", overrun, 1);
        check("overrun_busy", busy, 1);
        wait_valid(c);
        check("overrun_conv_latency", c, 5);
        set_src(8'h3C, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h05, 8'hFB);
        tick();
        wait_valid(c);
        check("tick_in_valid_latency", c, 11);
        check("overrun_sticky", overrun, 1);

        // Reset at E6 aborts the conversion without a valid pulse.
        set_src(8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h70, 8'h70);
        @(negedge Clk);
        tick();
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        saved = n_valid;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_overrun_clr", overrun, 0);
        repeat (20) @(negedge Clk);
        check("abort_no_valid", n_valid, saved);
        check("abort_left", left, 0);
        check("abort_right", right, 0);
        set_src(8'h02, 0, 0, 0, 0, 0, 0, 0, 8'hF0, 0);
        run("after_reset");

        // Inputs changed mid-conversion must not leak into the result.
        set_src(8'h99, 8'h44, 8'h88, 8'h22, 8'h66, 8'hAA, 8'hCC, 8'h33, 8'h90, 8'h10);
        @(negedge Clk);
        tick();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        set_src(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F);
        wait_valid(c);
        check("snapshot_latency", c, 9);

        repeat (3) @(negedge Clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
